// File: rtl/regfile_pkg.sv
// Shared constants, clear-FSM state type and register-array type for the
// register-file write side.
package regfile_pkg;

    localparam int REG_DATA_W = 64;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 2 ** REG_ADDR_W;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    typedef logic [REG_DATA_W-1:0] reg_array_t [REG_COUNT-1:0];

endpackage

// File: rtl/regfile_write_demux_if.sv
// Write/clear handshake plus the full register array presented to the read muxes.
interface regfile_write_demux_if;
    import regfile_pkg::*;

    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [REG_DATA_W-1:0] wr_data;
    logic                  wr_ready;
    logic                  clr_req;
    logic                  clr_busy;
    reg_array_t            regs_out;

    modport master (
        output wr_en, wr_addr, wr_data, clr_req,
        input  wr_ready, clr_busy, regs_out
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, clr_req,
        output wr_ready, clr_busy, regs_out
    );
endinterface

// File: rtl/regfile_write_demux_decoder.sv
// Enable-gated one-hot decode of the write address into per-register strobes.
module decoder_5to32
    import regfile_pkg::*;
(
    input  logic                  i_en,
    input  logic [REG_ADDR_W-1:0] i_addr,
    output logic [REG_COUNT-1:0]  o_onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < REG_COUNT; gi++) begin : g_dec
            assign o_onehot[gi] = i_en && (i_addr == REG_ADDR_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/regfile_write_demux.sv
// 32 x 64 register bank with one-hot write decode and a 32-cycle bulk-clear sweep.
// Optional: define REGFILE_ZERO_REG_EN to hardwire register 31 to zero.
module regfile_write_demux
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
)(
    input  logic                 clk,
    input  logic                 reset,
    regfile_write_demux_if.slave rf
);

    localparam int NREGS = 2 ** ADDR_W;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG_EN = 1'b1;
`else
    localparam bit ZERO_REG_EN = 1'b0;
`endif

    clr_state_e        r_state;
    clr_state_e        w_state_next;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_next;
    logic [NREGS-1:0]  w_wr_onehot;
    logic              w_wr_ready;

    assign w_wr_ready  = (r_state == IDLE);
    assign rf.wr_ready = w_wr_ready;
    assign rf.clr_busy = (r_state == CLEAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // The sweep index wraps 31 -> 0 on its own, so leaving CLEAR needs no reload.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            IDLE: begin
                if (rf.clr_req) begin
                    w_state_next = CLEAR;
                    w_idx_next   = '0;
                end
            end
            CLEAR: begin
                w_idx_next = r_idx + ADDR_W'(1);
                if (r_idx == ADDR_W'(NREGS - 1)) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    decoder_5to32 u_decoder (
        .i_en     (rf.wr_en && w_wr_ready),
        .i_addr   (rf.wr_addr),
        .o_onehot (w_wr_onehot)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            localparam bit IS_ZERO = ZERO_REG_EN && (gi == int'(ZERO_REG));
            logic [DATA_W-1:0] r_reg;
            logic              w_clr_hit;

            assign w_clr_hit = (r_state == CLEAR) && (r_idx == ADDR_W'(gi));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_reg <= '0;
                end else if (w_clr_hit) begin
                    r_reg <= '0;
                end else if (w_wr_onehot[gi] && !IS_ZERO) begin
                    r_reg <= rf.wr_data;
                end
            end

            assign rf.regs_out[gi] = IS_ZERO ? '0 : r_reg;
        end
    endgenerate

endmodule
